// File: rtl/store_trace_monitor.sv
// ---------------------------------------------------------------------------
// store_trace_monitor
//
// Watches the multicycle CPU store port and pc. Every accepted store is logged
// as {dataaddr, writedata, pc} into a first-word-fall-through FIFO for the
// bench to drain. The test is over when the CPU stores to DONE_ADDR: the
// stored value decides pass/fail. A pc-stall watchdog flags a hung CPU.
// DONE and HANG are terminal until reset; only the FIFO drain keeps working.
//
// Optional feature (macro STORE_TRACE_FILTER_EN): only stores whose address
// lies in [FILTER_LO, FILTER_HI] are pushed into the FIFO. Counting and the
// done check still see every store.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   pc         CPU program counter
//   memwrite   store strobe, one cycle per store
//   dataaddr   store address
//   writedata  store data
//   rd_en      pop the FIFO head
//   rd_valid   FIFO non-empty, head presented on rd_addr/rd_data/rd_pc
//   rd_addr    head entry address
//   rd_data    head entry data
//   rd_pc      head entry pc (sampled with the store)
//   store_cnt  stores observed, saturating
//   overflow   sticky, a store was dropped on a full FIFO
//   done       sticky, done store seen
//   pass       verdict, meaningful when done=1
//   hang       sticky, watchdog fired
// ---------------------------------------------------------------------------
module store_trace_monitor #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [31:0] DONE_ADDR   = 32'h0000_00FC,
  parameter logic [31:0] PASS_VALUE  = 32'h0000_0001,
  parameter int unsigned HANG_CYCLES = 64,
  parameter logic [31:0] FILTER_LO   = 32'h0000_0000,
  parameter logic [31:0] FILTER_HI   = 32'h0000_00FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        memwrite,
  input  logic [31:0] dataaddr,
  input  logic [31:0] writedata,
  input  logic        rd_en,
  output logic        rd_valid,
  output logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] rd_pc,
  output logic [15:0] store_cnt,
  output logic        overflow,
  output logic        done,
  output logic        pass,
  output logic        hang
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(HANG_CYCLES);
  localparam logic [SW-1:0] STALL_MAX = SW'(HANG_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_HANG} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  state_e        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic          pass_q, pass_d;
  logic          overflow_q, overflow_d;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic          empty, full, pop, push, hang_fire, in_window;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = rd_en && !empty;

`ifdef STORE_TRACE_FILTER_EN
  assign in_window = (dataaddr >= FILTER_LO) && (dataaddr <= FILTER_HI);
`else
  logic unused_filter;
  assign in_window     = 1'b1;
  assign unused_filter = ^{FILTER_LO, FILTER_HI};
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    stall_d    = stall_q;
    last_pc_d  = last_pc_q;
    pass_d     = pass_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    hang_fire  = 1'b0;

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    if (state_q == ST_RUN) begin
      last_pc_d = pc;
      if (pc == last_pc_q) begin
        if (stall_q == STALL_MAX) hang_fire = 1'b1;
        else                      stall_d   = stall_q + 1'b1;
      end else begin
        stall_d = '0;
      end

      if (memwrite) begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (in_window) begin
          // A simultaneous pop frees the slot, so a full FIFO still accepts.
          if (!full || pop) push       = 1'b1;
          else              overflow_d = 1'b1;
        end
      end

      // The done store has priority over a watchdog firing in the same cycle.
      if (memwrite && (dataaddr == DONE_ADDR)) begin
        state_d = ST_DONE;
        pass_d  = (writedata == PASS_VALUE);
      end else if (hang_fire) begin
        state_d = ST_HANG;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      stall_q    <= '0;
      last_pc_q  <= '0;
      pass_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      stall_q    <= stall_d;
      last_pc_q  <= last_pc_d;
      pass_q     <= pass_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; the head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{addr: dataaddr, data: writedata, pc: pc};
  end

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_valid  = !empty;
  assign rd_addr   = empty ? 32'd0 : head.addr;
  assign rd_data   = empty ? 32'd0 : head.data;
  assign rd_pc     = empty ? 32'd0 : head.pc;
  assign store_cnt = cnt_q;
  assign overflow  = overflow_q;
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign hang      = (state_q == ST_HANG);

endmodule

// File: tb/tb_store_trace_monitor.sv
// ---------------------------------------------------------------------------
// tb_store_trace_monitor
//
// Directed bench for store_trace_monitor with default parameters (DEPTH=8,
// DONE_ADDR=0xFC, PASS_VALUE=1, HANG_CYCLES=64). Inputs are driven 1 ns after
// the rising edge and outputs are read at that same point, away from the edge.
// pc advances by 4 every cycle unless pc_hold is set, so the watchdog stays
// quiet outside the tests that target it.
// ---------------------------------------------------------------------------
module tb_store_trace_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        memwrite;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic        rd_en;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [31:0] rd_pc;
  logic [15:0] store_cnt;
  logic        overflow;
  logic        done;
  logic        pass;
  logic        hang;

  logic        pc_hold;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] spc [16];

  store_trace_monitor dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .memwrite (memwrite),
    .dataaddr (dataaddr),
    .writedata(writedata),
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_pc    (rd_pc),
    .store_cnt(store_cnt),
    .overflow (overflow),
    .done     (done),
    .pass     (pass),
    .hang     (hang)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!pc_hold) pc = pc + 32'd4;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    pc_hold  = 1'b0;
    pc       = 32'h0000_0100;
    memwrite = 1'b0;
    dataaddr = '0;
    writedata = '0;
    rd_en    = 1'b0;
    #3;
    reset = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic do_pop,
                       output logic [31:0] sampled_pc);
    memwrite   = 1'b1;
    dataaddr   = a;
    writedata  = d;
    rd_en      = do_pop;
    sampled_pc = pc;
    tick();
    memwrite  = 1'b0;
    dataaddr  = '0;
    writedata = '0;
    rd_en     = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                           input logic [31:0] ep);
    check({tag, ".valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, ".addr"}, rd_addr, ea);
    check({tag, ".data"}, rd_data, ed);
    check({tag, ".pc"}, rd_pc, ep);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rd_valid"}, {31'd0, rd_valid}, 32'd0);
    check({tag, ".rd_addr"}, rd_addr, 32'd0);
    check({tag, ".rd_data"}, rd_data, 32'd0);
    check({tag, ".rd_pc"}, rd_pc, 32'd0);
    check({tag, ".store_cnt"}, {16'd0, store_cnt}, 32'd0);
    check({tag, ".overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, ".done"}, {31'd0, done}, 32'd0);
    check({tag, ".pass"}, {31'd0, pass}, 32'd0);
    check({tag, ".hang"}, {31'd0, hang}, 32'd0);
  endtask

  initial begin
    logic [31:0] tmp;

    // Reset state.
    do_reset();
    #1;
    check_all_zero("reset");
    tick();

    // Three stores, FIFO latency of one cycle, in-order drain with sampled pc.
    store(32'h10, 32'd1, 1'b0, spc[0]);
    check("lat.valid", {31'd0, rd_valid}, 32'd1);
    check("lat.addr", rd_addr, 32'h10);
    store(32'h14, 32'd2, 1'b0, spc[1]);
    store(32'h18, 32'd3, 1'b0, spc[2]);
    check("three.cnt", {16'd0, store_cnt}, 32'd3);
    pop_check("three.e0", 32'h10, 32'd1, spc[0]);
    pop_check("three.e1", 32'h14, 32'd2, spc[1]);
    pop_check("three.e2", 32'h18, 32'd3, spc[2]);
    check("three.empty", {31'd0, rd_valid}, 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("underflow.valid", {31'd0, rd_valid}, 32'd0);
    check("underflow.addr", rd_addr, 32'd0);
    store(32'h1C, 32'd4, 1'b0, spc[3]);
    pop_check("after_underflow", 32'h1C, 32'd4, spc[3]);

    // Nine stores without popping: ninth is dropped.
    do_reset();
    tick();
    for (int i = 0; i < 9; i++) store(32'h20 + 32'(4 * i), 32'h100 + 32'(i), 1'b0, spc[i]);
    check("ovf.flag", {31'd0, overflow}, 32'd1);
    check("ovf.cnt", {16'd0, store_cnt}, 32'd9);
    for (int i = 0; i < 8; i++) pop_check("ovf.drain", 32'h20 + 32'(4 * i), 32'h100 + 32'(i), spc[i]);
    check("ovf.lost", {31'd0, rd_valid}, 32'd0);

    // Ninth store coincides with a pop on a full FIFO: no overflow.
    do_reset();
    tick();
    for (int i = 0; i < 8; i++) store(32'h20 + 32'(4 * i), 32'h200 + 32'(i), 1'b0, spc[i]);
    store(32'h40, 32'h208, 1'b1, spc[8]);
    check("fullpop.flag", {31'd0, overflow}, 32'd0);
    check("fullpop.cnt", {16'd0, store_cnt}, 32'd9);
    for (int i = 1; i < 9; i++) pop_check("fullpop.drain", 32'h20 + 32'(4 * i), 32'h200 + 32'(i), spc[i]);
    check("fullpop.empty", {31'd0, rd_valid}, 32'd0);

    // Done store with pass value; later stores are frozen out.
    do_reset();
    tick();
    store(32'hFC, 32'd1, 1'b0, spc[0]);
    check("done1.done", {31'd0, done}, 32'd1);
    check("done1.pass", {31'd0, pass}, 32'd1);
    check("done1.cnt", {16'd0, store_cnt}, 32'd1);
    store(32'h30, 32'd9, 1'b0, tmp);
    check("done1.frozen_cnt", {16'd0, store_cnt}, 32'd1);
    pop_check("done1.entry", 32'hFC, 32'd1, spc[0]);
    check("done1.not_enq", {31'd0, rd_valid}, 32'd0);
    check("done1.still_done", {31'd0, done}, 32'd1);

    // Done store with a failing value.
    do_reset();
    tick();
    store(32'hFC, 32'd0, 1'b0, spc[0]);
    check("done0.done", {31'd0, done}, 32'd1);
    check("done0.pass", {31'd0, pass}, 32'd0);

    // Watchdog: 64 consecutive unchanged-pc cycles fire hang on the 64th.
    do_reset();
    pc_hold = 1'b1;
    pc = 32'h0040_0008;
    tick();
    for (int i = 0; i < 63; i++) tick();
    check("hang.before", {31'd0, hang}, 32'd0);
    tick();
    check("hang.fire", {31'd0, hang}, 32'd1);
    store(32'h80, 32'd5, 1'b0, tmp);
    check("hang.frozen_cnt", {16'd0, store_cnt}, 32'd0);
    check("hang.not_enq", {31'd0, rd_valid}, 32'd0);
    check("hang.no_done", {31'd0, done}, 32'd0);

    // pc changing every 63 cycles never fires.
    do_reset();
    pc_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc = 32'h0040_0000 + 32'(16 * k);
      for (int i = 0; i < 63; i++) tick();
    end
    check("nohang", {31'd0, hang}, 32'd0);

    // Done store lands on the exact cycle the watchdog would fire.
    do_reset();
    pc_hold = 1'b1;
    pc = 32'h0000_0500;
    tick();
    for (int i = 0; i < 63; i++) tick();
    check("race.pre_hang", {31'd0, hang}, 32'd0);
    store(32'hFC, 32'd1, 1'b0, tmp);
    check("race.done", {31'd0, done}, 32'd1);
    check("race.hang", {31'd0, hang}, 32'd0);
    check("race.pass", {31'd0, pass}, 32'd1);

    // Asynchronous reset mid-cycle with four entries queued and done set.
    do_reset();
    tick();
    store(32'h10, 32'd1, 1'b0, tmp);
    store(32'h14, 32'd2, 1'b0, tmp);
    store(32'h18, 32'd3, 1'b0, tmp);
    store(32'hFC, 32'd1, 1'b0, tmp);
    check("pre_async.done", {31'd0, done}, 32'd1);
    check("pre_async.cnt", {16'd0, store_cnt}, 32'd4);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async");
    reset = 1'b1;
    tick();
    store(32'h44, 32'd7, 1'b0, spc[0]);
    check("resume.cnt", {16'd0, store_cnt}, 32'd1);
    pop_check("resume.entry", 32'h44, 32'd7, spc[0]);

`ifdef STORE_TRACE_FILTER_EN
    // Out-of-window store is counted but not logged.
    do_reset();
    tick();
    store(32'h200, 32'd1, 1'b0, tmp);
    store(32'h20, 32'd2, 1'b0, spc[0]);
    check("filt.cnt", {16'd0, store_cnt}, 32'd2);
    pop_check("filt.entry", 32'h20, 32'd2, spc[0]);
    check("filt.only_one", {31'd0, rd_valid}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
